// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory/IO controller: device map, FSM encoding,
// and the position of the ready bit in KBSR/DSR.
package lc3_pkg;

  localparam int          RDY_BIT   = 15;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

endpackage

// File: rtl/lc3_mem_io_ctrl_if.sv
// External memory bus between the controller (master) and the memory model (slave).
interface lc3_mem_io_ctrl_if #(
  parameter int WID = 16
);

  // Handshake: master raises mem_req with mem_we/mem_addr/mem_wdata stable and holds
  // them until the slave returns a single-cycle mem_ack; an ack while mem_req=0 is ignored.
  logic           mem_req;
  logic           mem_we;
  logic [WID-1:0] mem_addr;
  logic [WID-1:0] mem_wdata;
  logic [WID-1:0] mem_rdata;
  logic           mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/lc3_io_regs.sv
// LC-3 memory-mapped device registers (KBSR/KBDR/DSR/DDR) with keyboard capture
// and display output handshake.
module lc3_io_regs
  import lc3_pkg::*;
#(
  parameter int             WID    = 16,
  parameter logic [WID-1:0] KBSR_A = WID'(KBSR_ADDR),
  parameter logic [WID-1:0] KBDR_A = WID'(KBDR_ADDR),
  parameter logic [WID-1:0] DSR_A  = WID'(DSR_ADDR),
  parameter logic [WID-1:0] DDR_A  = WID'(DDR_ADDR)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           acc,
  input  logic           rw,
  input  logic [WID-1:0] addr,
  input  logic [7:0]     wbyte,
  input  logic           kb_valid,
  input  logic [7:0]     kb_data,
  input  logic           dsp_ready,
  output logic           hit,
  output logic [WID-1:0] rd_val,
  output logic           dsp_valid,
  output logic [7:0]     dsp_data
);

  logic       sel_kbsr;
  logic       sel_kbdr;
  logic       sel_dsr;
  logic       sel_ddr;
  logic       kbsr_rdy;
  logic [7:0] kbdr;
  logic       dsr_rdy;

  assign sel_kbsr = (addr == KBSR_A);
  assign sel_kbdr = (addr == KBDR_A);
  assign sel_dsr  = (addr == DSR_A);
  assign sel_ddr  = (addr == DDR_A);
  assign hit      = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr;

  // DDR reads as zero; only the status ready bits and the keyboard byte are visible.
  always_comb begin
    rd_val = '0;
    if (sel_kbsr) begin
      rd_val[RDY_BIT] = kbsr_rdy;
    end else if (sel_dsr) begin
      rd_val[RDY_BIT] = dsr_rdy;
    end else if (sel_kbdr) begin
      rd_val[7:0] = kbdr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbsr_rdy  <= 1'b0;
      kbdr      <= '0;
      dsr_rdy   <= 1'b1;
      dsp_valid <= 1'b0;
      dsp_data  <= '0;
    end else begin
      if (acc && !rw && sel_kbdr) begin
        kbsr_rdy <= 1'b0;
      end
      // A new keystroke overrides the clear from a same-cycle KBDR read.
      if (kb_valid) begin
        kbdr     <= kb_data;
        kbsr_rdy <= 1'b1;
      end
      // dsr_rdy=1 implies dsp_valid=0, so an accepted write never races the drain.
      if (acc && rw && sel_ddr && dsr_rdy) begin
        dsp_data  <= wbyte;
        dsp_valid <= 1'b1;
        dsr_rdy   <= 1'b0;
      end else if (dsp_valid && dsp_ready) begin
        dsp_valid <= 1'b0;
        dsr_rdy   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc3_mem_io_ctrl.sv
// LC-3 memory/IO access sequencer: decodes MAR, runs device or external memory
// accesses, and returns read data with the one-cycle R (ready) pulse.
module lc3_mem_io_ctrl
  import lc3_pkg::*;
#(
  parameter int             WID     = 16,
  parameter int             TIMEOUT = 15,
  parameter logic [WID-1:0] KBSR_A  = WID'(KBSR_ADDR),
  parameter logic [WID-1:0] KBDR_A  = WID'(KBDR_ADDR),
  parameter logic [WID-1:0] DSR_A   = WID'(DSR_ADDR),
  parameter logic [WID-1:0] DDR_A   = WID'(DDR_ADDR)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mio_en,
  input  logic                   rw,
  input  logic [WID-1:0]         addr,
  input  logic [WID-1:0]         wdata,
  output logic [WID-1:0]         rdata,
  output logic                   ready,
  output logic                   err,
  lc3_mem_io_ctrl_if.master      mem,
  input  logic                   kb_valid,
  input  logic [7:0]             kb_data,
  output logic                   dsp_valid,
  output logic [7:0]             dsp_data,
  input  logic                   dsp_ready,
  output state_t                 dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           req_q;
  logic           we_q;
  logic [WID-1:0] maddr_q;
  logic [WID-1:0] mwdata_q;
  logic           dev_hit;
  logic [WID-1:0] dev_rd;
  logic           dev_acc;

  assign dev_acc       = (state == ST_IDLE) && mio_en && dev_hit;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = mwdata_q;
  assign dbg_state     = state;

  lc3_io_regs #(
    .WID    (WID),
    .KBSR_A (KBSR_A),
    .KBDR_A (KBDR_A),
    .DSR_A  (DSR_A),
    .DDR_A  (DDR_A)
  ) u_io_regs (
    .clk       (clk),
    .reset     (reset),
    .acc       (dev_acc),
    .rw        (rw),
    .addr      (addr),
    .wbyte     (wdata[7:0]),
    .kb_valid  (kb_valid),
    .kb_data   (kb_data),
    .dsp_ready (dsp_ready),
    .hit       (dev_hit),
    .rd_val    (dev_rd),
    .dsp_valid (dsp_valid),
    .dsp_data  (dsp_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rdata    <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mio_en) begin
            if (dev_hit) begin
              if (!rw) begin
                rdata <= dev_rd;
              end
              ready <= 1'b1;
              state <= ST_DONE;
            end else begin
              req_q    <= 1'b1;
              we_q     <= rw;
              maddr_q  <= addr;
              mwdata_q <= wdata;
              cnt      <= '0;
              state    <= ST_MEM_WAIT;
            end
          end
        end
        ST_MEM_WAIT: begin
          // Ack is checked first so an ack on the final allowed cycle still completes cleanly.
          if (mem.mem_ack) begin
            if (!we_q) begin
              rdata <= mem.mem_rdata;
            end
            req_q <= 1'b0;
            we_q  <= 1'b0;
            ready <= 1'b1;
            state <= ST_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            rdata <= '0;
            ready <= 1'b1;
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          ready <= 1'b0;
          err   <= 1'b0;
          req_q <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
